// File: rtl/i2s_tx_frame_ctrl.sv
// I2S transmit frame controller: divides aud_mclk into sclk, drives the
// word clock, fetches one stereo pair per frame and serializes it (I2S).
//
// Ports:
//   aud_mclk, aud_mrstn   clock, async active-low reset
//   ctrl_en               core enable; a stop takes effect at a frame boundary
//   sclk_div              sclk half-period in aud_mclk cycles (0 acts as 1)
//   smp_valid/left/right  upstream stereo sample pair
//   smp_ready             one-cycle take strobe at each frame boundary
//   sclk_out, lrclk_out   bit clock and word clock (0 = left slot)
//   sdata_out             serial data, updated when sclk falls
//   underflow             one-cycle pulse: boundary with no valid sample
//   busy                  high while START or RUN
module i2s_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                  aud_mclk,
    input  logic                  aud_mrstn,
    input  logic                  ctrl_en,
    input  logic [DIV_WIDTH-1:0]  sclk_div,
    input  logic                  smp_valid,
    input  logic [DATA_WIDTH-1:0] smp_left,
    input  logic [DATA_WIDTH-1:0] smp_right,
    output logic                  smp_ready,
    output logic                  sclk_out,
    output logic                  lrclk_out,
    output logic                  sdata_out,
    output logic                  underflow,
    output logic                  busy
);

    localparam int BW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                state_q;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  div_cnt_q;
    logic [BW-1:0]         bit_cnt_q;
    logic                  ch_q;
    logic                  sclk_q;
    logic                  lrclk_q;
    logic                  sdata_q;
    logic                  ready_q;
    logic                  uflow_q;
    logic [DATA_WIDTH-1:0] left_q;
    logic [DATA_WIDTH-1:0] right_q;

    logic [DIV_WIDTH-1:0]  div_d;
    logic [BW-1:0]         bit_cnt_d;
    logic                  ch_d;
    logic                  sdata_d;
    logic [DATA_WIDTH-1:0] left_d;
    logic [DATA_WIDTH-1:0] right_d;
    logic                  div_wrap;
    logic                  fall;
    logic                  slot_end;
    logic                  frame_end;

    // Slot bit b: bit 0 is the I2S one-bit delay, bits 1..DATA_WIDTH carry
    // the sample MSB first, the rest of the slot is padded with zeros.
    function automatic logic slot_bit(
        input logic [DATA_WIDTH-1:0] s,
        input logic [BW-1:0]         b
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (int'(b) == DATA_WIDTH - i) begin
                r = s[i];
            end
        end
        return r;
    endfunction

    always_comb begin
        div_d     = (sclk_div == '0) ? DIV_WIDTH'(1) : sclk_div;
        div_wrap  = (div_cnt_q == div_q - DIV_WIDTH'(1));
        fall      = div_wrap & sclk_q;
        slot_end  = (bit_cnt_q == BW'(SLOT_WIDTH - 1));
        frame_end = fall & slot_end & ch_q;
        bit_cnt_d = slot_end ? '0 : bit_cnt_q + BW'(1);
        ch_d      = slot_end ? ~ch_q : ch_q;
        sdata_d   = slot_bit(ch_d ? right_q : left_q, bit_cnt_d);
        left_d    = smp_valid ? smp_left : '0;
        right_d   = smp_valid ? smp_right : '0;
    end

    always_ff @(posedge aud_mclk or negedge aud_mrstn) begin
        if (!aud_mrstn) begin
            state_q   <= IDLE;
            div_q     <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            ch_q      <= 1'b0;
            sclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            sdata_q   <= 1'b0;
            ready_q   <= 1'b0;
            uflow_q   <= 1'b0;
            left_q    <= '0;
            right_q   <= '0;
        end else begin
            ready_q <= 1'b0;
            uflow_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ctrl_en) begin
                        div_q   <= div_d;
                        state_q <= START;
                        ready_q <= 1'b1;
                        uflow_q <= ~smp_valid;
                        left_q  <= left_d;
                        right_q <= right_d;
                    end
                end
                // START is the first boundary cycle; the divider already
                // counts in it so the first sclk rise lands D cycles later.
                START, RUN: begin
                    state_q <= RUN;
                    if (div_wrap) begin
                        div_cnt_q <= '0;
                        sclk_q    <= ~sclk_q;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
                    end
                    if (frame_end) begin
                        bit_cnt_q <= '0;
                        ch_q      <= 1'b0;
                        lrclk_q   <= 1'b0;
                        sdata_q   <= 1'b0;
                        if (ctrl_en) begin
                            state_q <= START;
                            ready_q <= 1'b1;
                            uflow_q <= ~smp_valid;
                            left_q  <= left_d;
                            right_q <= right_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else if (fall) begin
                        bit_cnt_q <= bit_cnt_d;
                        ch_q      <= ch_d;
                        lrclk_q   <= ch_d;
                        sdata_q   <= sdata_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign smp_ready = ready_q;
    assign sclk_out  = sclk_q;
    assign lrclk_out = lrclk_q;
    assign sdata_out = sdata_q;
    assign underflow = uflow_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_i2s_tx_frame_ctrl.sv
// Scoreboard bench for i2s_tx_frame_ctrl: stimulus queues expected sclk
// bits and boundary events, a monitor pops and compares them.
module tb_i2s_tx_frame_ctrl;

    localparam int DW = 24;
    localparam int SW = 32;

    typedef struct {
        int   cyc;
        logic lr;
        logic sd;
    } bit_t;

    typedef struct {
        int   cyc;
        logic uf;
    } evt_t;

    logic          aud_mclk = 1'b0;
    logic          aud_mrstn;
    logic          ctrl_en;
    logic [7:0]    sclk_div;
    logic          smp_valid;
    logic [DW-1:0] smp_left;
    logic [DW-1:0] smp_right;
    logic          smp_ready;
    logic          sclk_out;
    logic          lrclk_out;
    logic          sdata_out;
    logic          underflow;
    logic          busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit_t bit_q[$];
    evt_t evt_q[$];

    i2s_tx_frame_ctrl #(
        .DATA_WIDTH(DW),
        .SLOT_WIDTH(SW),
        .DIV_WIDTH (8)
    ) dut (
        .aud_mclk (aud_mclk),
        .aud_mrstn(aud_mrstn),
        .ctrl_en  (ctrl_en),
        .sclk_div (sclk_div),
        .smp_valid(smp_valid),
        .smp_left (smp_left),
        .smp_right(smp_right),
        .smp_ready(smp_ready),
        .sclk_out (sclk_out),
        .lrclk_out(lrclk_out),
        .sdata_out(sdata_out),
        .underflow(underflow),
        .busy     (busy)
    );

    always #5 aud_mclk = ~aud_mclk;

    always @(posedge aud_mclk) cyc <= cyc + 1;

    function automatic logic [5:0] outs();
        return {smp_ready, sclk_out, lrclk_out, sdata_out, underflow, busy};
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge aud_mclk);
    endtask

    // Expected frame starting (boundary cycle) at sc with divider d.
    task automatic push_frame(input int sc, input int d,
                              input logic [DW-1:0] l,
                              input logic [DW-1:0] r,
                              input logic v);
        evt_t e;
        bit_t b;
        logic [DW-1:0] s;
        int k;
        e.cyc = sc;
        e.uf  = ~v;
        evt_q.push_back(e);
        for (int i = 0; i < 2 * SW; i++) begin
            k = i % SW;
            s = (i < SW) ? l : r;
            if (!v) s = '0;
            b.cyc = sc + d + i * 2 * d;
            b.lr  = (i >= SW);
            b.sd  = (k >= 1 && k <= DW) ? s[DW-k] : 1'b0;
            bit_q.push_back(b);
        end
    endtask

    // Monitor
    initial begin
        logic sclk_prev;
        bit_t b;
        evt_t e;
        sclk_prev = 1'b0;
        forever begin
            @(negedge aud_mclk);
            if (!aud_mrstn) begin
                sclk_prev = 1'b0;
            end else begin
                if (sclk_out && !sclk_prev) begin
                    if (bit_q.size() == 0) begin
                        chk($sformatf("unexpected sclk rise @%0d", cyc), 1, 0);
                    end else begin
                        b = bit_q.pop_front();
                        chk($sformatf("sclk rise cycle @%0d", b.cyc), cyc, b.cyc);
                        chk($sformatf("lrclk @%0d", b.cyc), lrclk_out, b.lr);
                        chk($sformatf("sdata @%0d", b.cyc), sdata_out, b.sd);
                    end
                end
                if (smp_ready) begin
                    if (evt_q.size() == 0) begin
                        chk($sformatf("unexpected smp_ready @%0d", cyc), 1, 0);
                    end else begin
                        e = evt_q.pop_front();
                        chk($sformatf("smp_ready cycle @%0d", e.cyc), cyc, e.cyc);
                        chk($sformatf("underflow @%0d", e.cyc), underflow, e.uf);
                        chk($sformatf("lrclk at boundary @%0d", e.cyc), lrclk_out, 0);
                        chk($sformatf("sclk at boundary @%0d", e.cyc), sclk_out, 0);
                    end
                end else if (underflow) begin
                    chk($sformatf("underflow without ready @%0d", cyc), 1, 0);
                end
                sclk_prev = sclk_out;
            end
        end
    end

    // Stimulus
    initial begin
        int t;
        aud_mrstn = 1'b0;
        ctrl_en   = 1'b0;
        sclk_div  = 8'd2;
        smp_valid = 1'b0;
        smp_left  = '0;
        smp_right = '0;
        repeat (3) @(negedge aud_mclk);
        chk("outputs in reset", outs(), 0);
        aud_mrstn = 1'b1;
        repeat (5) @(negedge aud_mclk);
        chk("outputs idle", outs(), 0);

        // Basic frame D=2
        smp_left  = 24'hA5A5A5;
        smp_right = 24'h5A5A5A;
        smp_valid = 1'b1;
        ctrl_en   = 1'b1;
        t = cyc + 1;
        push_frame(t, 2, 24'hA5A5A5, 24'h5A5A5A, 1'b1);
        goto(t);
        chk("busy in START", busy, 1);

        // Next boundary underflows; divider change must be ignored
        smp_valid = 1'b0;
        push_frame(t + 256, 2, 24'hA5A5A5, 24'h5A5A5A, 1'b0);
        goto(t + 100);
        sclk_div = 8'd7;

        t = t + 256;
        goto(t);
        smp_valid = 1'b1;
        smp_left  = 24'h123456;
        smp_right = 24'hFEDCBA;
        push_frame(t + 256, 2, 24'h123456, 24'hFEDCBA, 1'b1);
        t = t + 256;

        // Graceful stop at left slot bit 5
        goto(t + 21);
        ctrl_en = 1'b0;
        goto(t + 255);
        chk("busy before stop boundary", busy, 1);
        @(negedge aud_mclk);
        chk("outputs at stop boundary", outs(), 0);

        // Back-to-back restart with sclk_div=0 (D=1)
        sclk_div  = 8'd0;
        smp_left  = 24'h000001;
        smp_right = 24'h800000;
        ctrl_en   = 1'b1;
        t = cyc + 1;
        push_frame(t, 1, 24'h000001, 24'h800000, 1'b1);
        goto(t + 10);
        ctrl_en = 1'b0;
        goto(t + 127);
        chk("busy before D=1 stop", busy, 1);
        @(negedge aud_mclk);
        chk("outputs after D=1 stop", outs(), 0);

        // Largest divider D=255
        sclk_div  = 8'd255;
        smp_left  = 24'hC00003;
        smp_right = 24'hFFFFFF;
        ctrl_en   = 1'b1;
        t = cyc + 1;
        push_frame(t, 255, 24'hC00003, 24'hFFFFFF, 1'b1);
        goto(t + 1000);
        ctrl_en = 1'b0;
        goto(t + 32639);
        chk("busy before D=255 stop", busy, 1);
        @(negedge aud_mclk);
        chk("outputs after D=255 stop", outs(), 0);

        // Asynchronous reset in the middle of RUN
        sclk_div  = 8'd2;
        smp_left  = 24'h0F0F0F;
        smp_right = 24'hF0F0F0;
        ctrl_en   = 1'b1;
        t = cyc + 1;
        push_frame(t, 2, 24'h0F0F0F, 24'hF0F0F0, 1'b1);
        goto(t + 50);
        chk("busy before reset", busy, 1);
        #2;
        aud_mrstn = 1'b0;
        bit_q.delete();
        evt_q.delete();
        #1;
        chk("outputs right after async reset", outs(), 0);
        ctrl_en = 1'b0;
        @(negedge aud_mclk);
        aud_mrstn = 1'b1;
        repeat (40) @(negedge aud_mclk);
        chk("idle after reset release", outs(), 0);

        // Restart after reset: same timing as the first start
        smp_left  = 24'hA5A5A5;
        smp_right = 24'h5A5A5A;
        ctrl_en   = 1'b1;
        t = cyc + 1;
        push_frame(t, 2, 24'hA5A5A5, 24'h5A5A5A, 1'b1);
        goto(t);
        ctrl_en = 1'b0;
        goto(t + 255);
        @(negedge aud_mclk);
        chk("outputs after final stop", outs(), 0);

        chk("bit queue drained", bit_q.size(), 0);
        chk("event queue drained", evt_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
